// File: rtl/approx_mul_error_monitor.sv
// Exhaustive on-chip checker for a small approximate unsigned multiplier:
// sweeps every input vector, compares against the exact product, accumulates error statistics.
//
// state | meaning
// IDLE  | waiting for start, statistics hold last (possibly partial) values
// RUN   | driving vectors and sampling dut_out after DUT_LAT settle cycles
// DONE  | sweep complete, statistics frozen and valid
module approx_mul_error_monitor #(
    parameter int WA      = 2,
    parameter int WB      = 2,
    parameter int OUT_W   = 4,
    parameter int ET      = 2,
    parameter int DUT_LAT = 0,
    localparam int IN_W   = WA + WB
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [IN_W-1:0]       stim,
    input  logic [OUT_W-1:0]      dut_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [OUT_W-1:0]      max_err,
    output logic [IN_W:0]         err_cnt,
    output logic [IN_W:0]         viol_cnt,
    output logic [OUT_W+IN_W-1:0] err_sum,
    output logic [IN_W-1:0]       first_viol
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0]       LAT_V = 4'(DUT_LAT);
    localparam logic [OUT_W-1:0] ET_V  = OUT_W'(ET);

    state_t                  state_q, state_d;
    logic [IN_W-1:0]         vec_q, vec_d;
    logic [3:0]              hold_q, hold_d;
    logic [OUT_W-1:0]        max_err_q, max_err_d;
    logic [IN_W:0]           err_cnt_q, err_cnt_d;
    logic [IN_W:0]           viol_cnt_q, viol_cnt_d;
    logic [OUT_W+IN_W-1:0]   err_sum_q, err_sum_d;
    logic [IN_W-1:0]         first_viol_q, first_viol_d;

    logic [WA-1:0]           op_a;
    logic [WB-1:0]           op_b;
    logic [IN_W-1:0]         prod;
    logic [OUT_W-1:0]        exact;
    logic [OUT_W-1:0]        err;
    logic                    is_err;
    logic                    is_viol;
    logic                    sample;
    logic                    last_vec;

    // Error datapath works on the vector currently driven; the DUT is combinational on stim.
    always_comb begin
        op_a    = vec_q[WA-1:0];
        op_b    = vec_q[IN_W-1:WA];
        prod    = IN_W'(op_a) * IN_W'(op_b);
        exact   = OUT_W'(prod);
        err     = (dut_out >= exact) ? (dut_out - exact) : (exact - dut_out);
        is_err  = (err != '0);
        is_viol = (err > ET_V);
    end

    assign sample   = (state_q == S_RUN) && (hold_q == LAT_V);
    assign last_vec = (vec_q == {IN_W{1'b1}});

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        hold_d       = hold_q;
        max_err_d    = max_err_q;
        err_cnt_d    = err_cnt_q;
        viol_cnt_d   = viol_cnt_q;
        err_sum_d    = err_sum_q;
        first_viol_d = first_viol_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_RUN;
                    vec_d        = '0;
                    hold_d       = '0;
                    max_err_d    = '0;
                    err_cnt_d    = '0;
                    viol_cnt_d   = '0;
                    err_sum_d    = '0;
                    first_viol_d = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    vec_d   = '0;
                    hold_d  = '0;
                end else if (sample) begin
                    if (err > max_err_q)
                        max_err_d = err;
                    err_sum_d = err_sum_q + (OUT_W+IN_W)'(err);
                    err_cnt_d = err_cnt_q + (IN_W+1)'(is_err);
                    if (is_viol) begin
                        viol_cnt_d = viol_cnt_q + 1'b1;
                        if (viol_cnt_q == '0)
                            first_viol_d = vec_q;
                    end
                    // Last vector keeps stim parked on it through DONE.
                    if (last_vec) begin
                        state_d = S_DONE;
                    end else begin
                        vec_d  = vec_q + 1'b1;
                        hold_d = '0;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                vec_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            vec_q        <= '0;
            hold_q       <= '0;
            max_err_q    <= '0;
            err_cnt_q    <= '0;
            viol_cnt_q   <= '0;
            err_sum_q    <= '0;
            first_viol_q <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            hold_q       <= hold_d;
            max_err_q    <= max_err_d;
            err_cnt_q    <= err_cnt_d;
            viol_cnt_q   <= viol_cnt_d;
            err_sum_q    <= err_sum_d;
            first_viol_q <= first_viol_d;
        end
    end

    assign stim       = vec_q;
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign pass       = (state_q == S_DONE) && (viol_cnt_q == '0);
    assign max_err    = max_err_q;
    assign err_cnt    = err_cnt_q;
    assign viol_cnt   = viol_cnt_q;
    assign err_sum    = err_sum_q;
    assign first_viol = first_viol_q;

endmodule

// File: doc/approx_mul_error_monitor.md
# approx_mul_error_monitor

Sequential exhaustive error monitor for the small approximate unsigned multipliers produced by the synthesis flow (e.g. 2x2-bit, 4-in/4-out). It drives every input vector into a combinational approximate-multiplier netlist and compares each returned output against the exact product. It accumulates error statistics and issues a pass/fail verdict against a configured error threshold. It sits beside the generated netlist in silicon or FPGA bring-up as the on-chip checker for the error-threshold (ET) guarantee.

## Interface
- WA, 2, operand A width; A = stim[WA-1:0]
- WB, 2, operand B width; B = stim[WA+WB-1:WA]
- OUT_W, 4, DUT output width; must be >= WA+WB
- ET, 2, maximum permitted absolute error; error > ET is a violation
- DUT_LAT, 0, extra settle cycles before sampling dut_out (0..15)
- IN_W = WA+WB (derived, not overridable)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a sweep; honoured only in IDLE or DONE
- abort  in  1  synchronous sweep cancel
- stim  out  IN_W  vector driven to the DUT inputs, registered
- dut_out  in  OUT_W  DUT output, combinational function of stim
- busy  out  1  high while sweeping
- done  out  1  high in DONE state; results valid
- pass  out  1  done & (viol_cnt == 0)
- max_err  out  OUT_W  largest |dut_out - exact| seen
- err_cnt  out  IN_W+1  vectors with nonzero error
- viol_cnt  out  IN_W+1  vectors with error > ET
- err_sum  out  OUT_W+IN_W  sum of absolute errors
- first_viol  out  IN_W  vector index of first violation; valid when viol_cnt != 0

## Operation
- States: IDLE, RUN, DONE.
- Reset sets state to IDLE and every output to 0, including stim, busy, done, pass and all statistics.
- IDLE/DONE + start: clear all statistics, vec=0, hold=0, go to RUN. Leaving DONE drops done and pass in the same edge.
- RUN:
  - stim = vec.
  - hold counts 0..DUT_LAT.
  - When hold == DUT_LAT, sample dut_out:
    - exact = A*B, zero-extended to OUT_W.
    - err = |dut_out - exact|, computed in OUT_W+1 bits, result fits OUT_W.
    - max_err = max(max_err, err).
    - err_sum += err.
    - err_cnt += (err != 0).
    - if err > ET: viol_cnt += 1, and first_viol = vec if viol_cnt was 0.
  - Then, if vec == 2^IN_W-1, go to DONE; else vec += 1 and hold = 0.
- DONE: stim holds the last vector. Statistics are frozen until the next start.
- start while in RUN is ignored.
- abort in RUN: go to IDLE and set stim=0. Statistics keep their partial values. done never asserts for that sweep.
- abort and start in the same cycle while in RUN: abort wins. In IDLE/DONE, start wins and abort is ignored.
- No counter can overflow. Maxima: err_cnt/viol_cnt = 2^IN_W; err_sum <= (2^OUT_W-1)*2^IN_W.

## Timing
- start sampled at edge T0: busy=1 and stim=0 from T0.
- Vector k is sampled at the edge ending cycle (k*(DUT_LAT+1) + DUT_LAT) after T0.
- Total sweep length: 2^IN_W*(DUT_LAT+1) cycles. DONE, done=1 and final statistics appear together on the following edge, with busy=0.
- Statistics update one edge after each sample. Intermediate values are observable but are guaranteed only in DONE.
- dut_out must settle within DUT_LAT+1 cycles of stim changing. stim changes only on the edge after a sample.
- Asynchronous rst mid-sweep clears everything immediately. No done pulse is produced. A new start is required.

## Test plan
- Exact loopback (dut_out = A*B), DUT_LAT=0, start pulse: busy for exactly 16 cycles. Then done=1, pass=1, max_err=0, err_cnt=0, viol_cnt=0, err_sum=0.
- Stuck-zero DUT (dut_out=0): max_err=9, err_sum=36, err_cnt=9, viol_cnt=6, first_viol=7, pass=0.
- Exact product XOR 1: max_err=1, err_cnt=16, err_sum=16, viol_cnt=0, pass=1. Repeat with DUT_LAT=2: busy lasts 48 cycles, and stim steps every 3 cycles.
- Mid-sweep events with exact loopback:
  - assert start at vector 5: no effect on stim or timing.
  - abort at vector 9: returns to IDLE with stim=0 and done=0.
  - a new start: clears statistics and completes a normal 16-cycle sweep.
- Asynchronous rst asserted mid-cycle during vector 10 of the stuck-zero sweep: all outputs 0 immediately, state IDLE. Second start after release reproduces max_err=9 and err_sum=36.
- Back-to-back sweeps: start in DONE with stuck-zero results, then switch dut_out to exact. done drops the next edge, statistics clear, and the second sweep ends with pass=1.
